// File: rtl/tt_pkg.sv
// ----------------------------------------------------------------------------
// tt_pkg
// Shared types and widths for the truth-table scan controller and its lookup.
//   state_t : controller FSM states
//   A_W/B_W : lookup operand widths, Y_W : lookup result width
//   IDX_W   : sweep index width (a, b and x concatenated)
//   N_COMB  : number of input combinations visited by one sweep
// ----------------------------------------------------------------------------
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int A_W    = 3;
  localparam int B_W    = 4;
  localparam int Y_W    = 3;
  localparam int IDX_W  = A_W + B_W + 1;
  localparam int N_COMB = 1 << IDX_W;

endpackage

// File: rtl/tt_lookup.sv
// ----------------------------------------------------------------------------
// tt_lookup
// Purely combinational 3-bit truth-table lookup, rules evaluated in priority
// order.
//   a : operand a (A_W bits)
//   b : operand b (B_W bits)
//   x : single-bit operand
//   y : lookup result (Y_W bits)
// ----------------------------------------------------------------------------
module tt_lookup
  import tt_pkg::*;
(
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           x,
  output logic [Y_W-1:0] y
);

  always_comb begin
    // NOTE: y gets a default before any branch, so no path leaves it unassigned
    // and no latch can be inferred.
    y = Y_W'(1);
    if (a == A_W'(4) && b == B_W'(1) && !x) begin
      y = Y_W'(3);
    end else if (a == A_W'(1) || a == A_W'(3)) begin
      if (b == B_W'(1) && !x)     y = Y_W'(2);
      else if (b == B_W'(4) && x) y = Y_W'(0);
      else                        y = Y_W'(1);
    end else if (a == A_W'(7) && b == B_W'(2) && x) begin
      y = Y_W'(2);
    end
  end

endmodule

// File: rtl/truthtable_scan_ctrl.sv
// ----------------------------------------------------------------------------
// truthtable_scan_ctrl
// Sweeps all input combinations through one shared tt_lookup and histograms
// the results; while idle, serves single-shot queries to the same lookup.
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start, abort    : begin a sweep / terminate a sweep in progress
//   busy, done      : sweep in progress (SCAN/DRAIN) / one-cycle completion
//   cnt0..cnt3      : histogram counts for y = 0..3
//   q_valid, q_a, q_b, q_x, q_ready : query request handshake and operands
//   r_valid, r_y    : one-cycle response pulse and registered query result
// ----------------------------------------------------------------------------
module truthtable_scan_ctrl
  import tt_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  input  logic             q_valid,
  input  logic [A_W-1:0]   q_a,
  input  logic [B_W-1:0]   q_b,
  input  logic             q_x,
  output logic             q_ready,
  output logic             r_valid,
  output logic [Y_W-1:0]   r_y
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [Y_W-1:0]   y_q;
  logic             y_v;
  logic [CNT_W-1:0] cnt [4];

  logic [A_W-1:0]   lk_a;
  logic [B_W-1:0]   lk_b;
  logic             lk_x;
  logic [Y_W-1:0]   lk_y;
  logic             q_fire;

  // The sweep owns the lookup in SCAN; otherwise it serves queries.
  always_comb begin
    if (state == SCAN) begin
      lk_a = idx[IDX_W-1 -: A_W];
      lk_b = idx[B_W:1];
      lk_x = idx[0];
    end else begin
      lk_a = q_a;
      lk_b = q_b;
      lk_x = q_x;
    end
  end

  tt_lookup u_lookup (
    .a (lk_a),
    .b (lk_b),
    .x (lk_x),
    .y (lk_y)
  );

  // Start wins over a query in the same cycle; no handshake while in reset.
  assign q_ready = rst_n && (state == IDLE) && !start;
  assign q_fire  = q_valid && q_ready;

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];

  // NOTE: the four counters are ordinary flops, not a RAM, so they are reset
  // together with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      y_q     <= '0;
      y_v     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_valid <= 1'b0;
      r_y     <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value regardless of statement order.
      done    <= 1'b0;
      r_valid <= q_fire;
      if (q_fire) r_y <= lk_y;

      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            idx   <= '0;
            y_v   <= 1'b0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (abort) begin
            // Drop the in-flight result; partial counts are kept.
            y_v   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (y_v && !y_q[2]) cnt[y_q[1:0]] <= cnt[y_q[1:0]] + CNT_W'(1);
            y_q <= lk_y;
            y_v <= 1'b1;
            if (idx == IDX_W'(N_COMB - 1)) state <= DRAIN;
            else                           idx   <= idx + IDX_W'(1);
          end
        end

        DRAIN: begin
          y_v  <= 1'b0;
          busy <= 1'b0;
          if (abort) begin
            state <= IDLE;
          end else begin
            if (y_v && !y_q[2]) cnt[y_q[1:0]] <= cnt[y_q[1:0]] + CNT_W'(1);
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truthtable_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_truthtable_scan_ctrl
// Directed bench for truthtable_scan_ctrl: full sweep histogram, queries,
// abort, query stall during a sweep, start priority, asynchronous reset.
// ----------------------------------------------------------------------------
module tb_truthtable_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic       busy, done;
  logic [8:0] cnt0, cnt1, cnt2, cnt3;
  logic       q_valid;
  logic [2:0] q_a;
  logic [3:0] q_b;
  logic       q_x;
  logic       q_ready, r_valid;
  logic [2:0] r_y;

  int n_pass  = 0;
  int n_total = 0;

  truthtable_scan_ctrl #(.CNT_W(9)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .cnt3    (cnt3),
    .q_valid (q_valid),
    .q_a     (q_a),
    .q_b     (q_b),
    .q_x     (q_x),
    .q_ready (q_ready),
    .r_valid (r_valid),
    .r_y     (r_y)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance one clock and settle 1ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
    check({tag, "_cnt0"}, 32'(cnt0), 32'(e0));
    check({tag, "_cnt1"}, 32'(cnt1), 32'(e1));
    check({tag, "_cnt2"}, 32'(cnt2), 32'(e2));
    check({tag, "_cnt3"}, 32'(cnt3), 32'(e3));
  endtask

  // Full sweep from IDLE: expects 257 busy cycles, then one done pulse and
  // the reference histogram (2 / 250 / 3 / 1). q_ready and r_valid must stay
  // low throughout, whatever q_valid does.
  task automatic run_sweep(input string tag);
    int busy_cycles = 0;
    int done_early  = 0;
    int qr_seen     = 0;
    int rv_seen     = 0;
    bit finished    = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    busy_cycles = 1;
    for (int i = 0; i < 400; i++) begin
      if (q_ready) qr_seen++;
      if (r_valid) rv_seen++;
      tick();
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      busy_cycles++;
      if (done) done_early++;
    end
    check({tag, "_finished"},    32'(finished),    32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd257);
    check({tag, "_done_pulse"},  32'(done),        32'd1);
    check({tag, "_done_early"},  32'(done_early),  32'd0);
    check({tag, "_qready_busy"}, 32'(qr_seen),     32'd0);
    check({tag, "_rvalid_busy"}, 32'(rv_seen),     32'd0);
    check({tag, "_qready_done"}, 32'(q_ready),     32'd0);
    check_counts(tag, 2, 250, 3, 1);
    tick();
    check({tag, "_done_fall"},   32'(done),        32'd0);
    check({tag, "_idle_busy"},   32'(busy),        32'd0);
  endtask

  task automatic query(input string tag, input logic [2:0] a, input logic [3:0] b,
                       input logic x, input logic [2:0] exp);
    q_valid = 1'b1;
    q_a = a;
    q_b = b;
    q_x = x;
    #1;
    check({tag, "_ready"}, 32'(q_ready), 32'd1);
    tick();
    q_valid = 1'b0;
    check({tag, "_rvalid"}, 32'(r_valid), 32'd1);
    check({tag, "_ry"},     32'(r_y),     32'(exp));
    tick();
    check({tag, "_rvalid_fall"}, 32'(r_valid), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    q_valid = 1'b0;
    q_a     = '0;
    q_b     = '0;
    q_x     = 1'b0;

    // Reset state
    #20;
    check("rst_busy",   32'(busy),    32'd0);
    check("rst_done",   32'(done),    32'd0);
    check("rst_qready", 32'(q_ready), 32'd0);
    check("rst_rvalid", 32'(r_valid), 32'd0);
    check("rst_ry",     32'(r_y),     32'd0);
    check_counts("rst", 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();

    // 1. Full sweep
    run_sweep("sweep1");
    check("sweep1_qready_idle", 32'(q_ready), 32'd1);

    // 2. Queries in IDLE, then a back-to-back pair
    query("q_4_1_0", 3'd4, 4'd1, 1'b0, 3'd3);
    query("q_3_4_1", 3'd3, 4'd4, 1'b1, 3'd0);
    q_valid = 1'b1; q_a = 3'd1; q_b = 4'd5; q_x = 1'b0;
    tick();
    q_a = 3'd7; q_b = 4'd2; q_x = 1'b1;
    check("b2b_first_rvalid", 32'(r_valid), 32'd1);
    check("b2b_first_ry",     32'(r_y),     32'd1);
    tick();
    q_valid = 1'b0;
    check("b2b_second_rvalid", 32'(r_valid), 32'd1);
    check("b2b_second_ry",     32'(r_y),     32'd2);
    tick();
    check("b2b_rvalid_fall", 32'(r_valid), 32'd0);
    check_counts("after_query", 2, 250, 3, 1);

    // 3. Abort after idx 0..9 have been captured: y(9) is discarded,
    //    y(0..8) = 1 are counted.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_counts("abort", 0, 9, 0, 0);
    begin
      int done_seen = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
    end
    check_counts("abort_hold", 0, 9, 0, 0);

    // 4. Query held across a sweep; accepted in the first IDLE cycle
    q_valid = 1'b1; q_a = 3'd4; q_b = 4'd1; q_x = 1'b0;
    run_sweep("sweep_q");
    check("held_q_ready", 32'(q_ready), 32'd1);
    tick();
    q_valid = 1'b0;
    check("held_q_rvalid", 32'(r_valid), 32'd1);
    check("held_q_ry",     32'(r_y),     32'd3);
    check_counts("held_q", 2, 250, 3, 1);

    // 5a. start and q_valid together: start wins
    tick();
    start = 1'b1;
    q_valid = 1'b1; q_a = 3'd7; q_b = 4'd2; q_x = 1'b1;
    #1;
    check("start_prio_qready", 32'(q_ready), 32'd0);
    tick();
    start = 1'b0;
    q_valid = 1'b0;
    check("start_prio_busy",   32'(busy),    32'd1);
    check("start_prio_rvalid", 32'(r_valid), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("start_prio_abort", 32'(busy), 32'd0);

    // 5b. start and abort together in IDLE: stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    tick();
    check("start_abort_busy2", 32'(busy), 32'd0);

    // 6. Asynchronous reset mid-SCAN, then a clean sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(busy),    32'd0);
    check("arst_done",   32'(done),    32'd0);
    check("arst_qready", 32'(q_ready), 32'd0);
    check("arst_rvalid", 32'(r_valid), 32'd0);
    check("arst_ry",     32'(r_y),     32'd0);
    check_counts("arst", 0, 0, 0, 0);
    #4 rst_n = 1'b1;
    run_sweep("sweep_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
